// File: rtl/booth_seq_mult.sv
// Sequential signed Booth multiplier with a start/busy/done handshake; product is held until the next result.
// Radix-2 by default; define BOOTH_RADIX4_EN for modified-Booth radix-4 (half the iterations).
module booth_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     m,
  input  logic [WIDTH-1:0]     q,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

`ifdef BOOTH_RADIX4_EN
  localparam int SHIFT = 2;
`else
  localparam int SHIFT = 1;
`endif
  // Extra accumulator headroom absorbs +-M (or +-2M) with M = -2^(WIDTH-1).
  localparam int AW    = WIDTH + SHIFT;
  localparam int ITERS = WIDTH / SHIFT;
  localparam int CW    = $clog2(ITERS + 1);

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic signed [AW-1:0]    m_q, m_d;
  logic signed [AW-1:0]    a_q, a_d;
  logic signed [AW-1:0]    addend, a_sum;
  logic [WIDTH-1:0]        q_q, q_d;
  logic                    qm1_q, qm1_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [2*WIDTH-1:0]      prod_q, prod_d;
  logic                    done_q, done_d;
  logic signed [AW+WIDTH:0] cat_s, sh_s;

`ifdef BOOTH_RADIX4_EN
  function automatic logic signed [AW-1:0] booth_addend(input logic signed [AW-1:0] mm,
                                                        input logic [2:0] trip);
    case (trip)
      3'b001, 3'b010: booth_addend = mm;
      3'b011:         booth_addend = mm <<< 1;
      3'b100:         booth_addend = -(mm <<< 1);
      3'b101, 3'b110: booth_addend = -mm;
      default:        booth_addend = '0;
    endcase
  endfunction
`else
  function automatic logic signed [AW-1:0] booth_addend(input logic signed [AW-1:0] mm,
                                                        input logic [1:0] pair);
    case (pair)
      2'b01:   booth_addend = mm;
      2'b10:   booth_addend = -mm;
      default: booth_addend = '0;
    endcase
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    done_d  = 1'b0;

`ifdef BOOTH_RADIX4_EN
    addend = booth_addend(m_q, {q_q[1:0], qm1_q});
`else
    addend = booth_addend(m_q, {q_q[0], qm1_q});
`endif
    a_sum = a_q + addend;
    // One combined arithmetic shift moves {A,Q,q_-1} together.
    cat_s = {a_sum, q_q, qm1_q};
    sh_s  = cat_s >>> SHIFT;

    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = {{SHIFT{m[WIDTH-1]}}, m};
          a_d     = '0;
          q_d     = q;
          qm1_d   = 1'b0;
          cnt_d   = CW'(ITERS);
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q != '0) begin
          a_d   = sh_s[AW+WIDTH:WIDTH+1];
          q_d   = sh_s[WIDTH:1];
          qm1_d = sh_s[0];
          cnt_d = cnt_q - CW'(1);
        end else begin
          prod_d  = {a_q[WIDTH-1:0], q_q};
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
    end
  end

  assign busy    = (state_q == CALC);
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Scoreboard bench for booth_seq_mult: accepted operations are queued, a negedge monitor checks each result.
module tb_booth_seq_mult;
  localparam int W = 8;
`ifdef BOOTH_RADIX4_EN
  localparam int LAT = W/2 + 1;
`else
  localparam int LAT = W + 1;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   m = '0;
  logic [W-1:0]   q = '0;
  logic           busy, done;
  logic [2*W-1:0] product;

  booth_seq_mult #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .m(m), .q(q),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] a; logic [W-1:0] b; int acc; } op_t;
  op_t            exp_q[$];
  logic [2*W-1:0] hold = '0;
  int             cyc = 0;
  int             checks = 0;
  int             errors = 0;
  bit             mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*W-1:0] ref_mul(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    longint p;
    p = longint'(a) * longint'(b);
    return p[2*W-1:0];
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: independent of the stimulus, driven only by the queue and DUT outputs.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", 64'(done), 64'd0);
        end else begin
          op_t op;
          logic [2*W-1:0] e;
          op = exp_q.pop_front();
          e  = ref_mul(op.a, op.b);
          chk("product", 64'(product), 64'(e));
          chk("latency", 64'(cyc - op.acc), 64'(LAT));
          chk("busy_at_done", 64'(busy), 64'd0);
          hold = e;
        end
      end else begin
        chk("busy", 64'(busy), 64'(exp_q.size() != 0));
        chk("product_hold", 64'(product), 64'(hold));
      end
    end
  end

  // Called at posedge+2 with the DUT idle; returns at posedge+2 just after the result edge.
  // mode 0: start low while busy; 1: random start/operands while busy; 2: start held high.
  task automatic issue(input int a, input int b, input int mode);
    op_t op;
    start = 1'b1;
    m = a[W-1:0];
    q = b[W-1:0];
    @(posedge clk);
    #1;
    op.a = a[W-1:0];
    op.b = b[W-1:0];
    op.acc = cyc;
    exp_q.push_back(op);
    #1;
    for (int i = 0; i < LAT; i++) begin
      start = (mode == 2) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      m = W'($urandom);
      q = W'($urandom);
      @(posedge clk);
      #2;
    end
    start = (mode == 2);
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    mon_en = 1'b1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_product", 64'(product), 64'd0);
    rst = 1'b0;
    idle(1);

    issue(4, 2, 0);
    idle(2);
    issue(-50, 50, 0);
    issue(30, -60, 0);
    issue(-5, 2, 0);
    idle(1);
    issue(-128, -128, 0);
    issue(-128, 127, 0);
    issue(0, -128, 0);
    issue(127, 127, 0);
    idle(1);

    // Start requests during busy must be ignored.
    start = 1'b1; m = W'(3); q = W'(3);
    issue(3, 3, 1);
    idle(2);

    // Reset mid-operation: everything clears at once and no done follows.
    begin
      op_t op;
      start = 1'b1; m = W'(4); q = W'(2);
      @(posedge clk);
      #1;
      op.a = W'(4); op.b = W'(2); op.acc = cyc;
      exp_q.push_back(op);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      exp_q.delete();
      hold = '0;
      #1;
      chk("midreset_busy", 64'(busy), 64'd0);
      chk("midreset_done", 64'(done), 64'd0);
      chk("midreset_product", 64'(product), 64'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      idle(LAT + 4);
    end
    issue(6, -7, 0);
    idle(1);

    // Back-to-back with start held high throughout.
    for (int i = 0; i < 6; i++) issue(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, 2);
    start = 1'b0;
    idle(2);

    // Randomized operations with random gaps and random start noise while busy.
    for (int i = 0; i < 60; i++) begin
      issue(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
            int'($urandom_range(0, 1)));
      start = 1'b0;
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end

    idle(LAT + 3);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
